ysyx_23060236_btb_2way: RTL and testbench

Two-way set-associative branch target buffer with 2-bit saturating direction counters. It replaces the single-entry BTB in the fetch path. It has two combinational lookup ports: IFU next-PC prediction and EXU check of the predicted PC. It has one registered update port, driven by the EXU when a control-transfer instruction resolves, plus a whole-table flush used on fence.i or a pipeline redirect policy change.

---
 rtl/ysyx_23060236_btb_2way_if.sv | 29 ++
 rtl/ysyx_23060236_btb_2way.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_23060236_btb_2way.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060236_btb_2way_if.sv
// Lookup and update signals between the fetch/execute units and the 2-way BTB.
// The master side drives addresses and updates, and the slave side returns predictions.
interface ysyx_23060236_btb_2way_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic [ADDR_LEN-1:0] btb_araddr;
    logic [DATA_LEN-1:0] btb_rdata;
    logic                btb_pred_taken;
    logic [ADDR_LEN-1:0] btb_araddr_exu;
    logic [DATA_LEN-1:0] btb_rdata_exu;
    logic                btb_wvalid;
    logic [ADDR_LEN-1:0] btb_awaddr;
    logic [DATA_LEN-1:0] btb_wdata;
    logic                btb_wtaken;
    logic                btb_flush;

    modport master (
        output btb_araddr, btb_araddr_exu,
        output btb_wvalid, btb_awaddr, btb_wdata, btb_wtaken, btb_flush,
        input  btb_rdata, btb_pred_taken, btb_rdata_exu
    );

    modport slave (
        input  btb_araddr, btb_araddr_exu,
        input  btb_wvalid, btb_awaddr, btb_wdata, btb_wtaken, btb_flush,
        output btb_rdata, btb_pred_taken, btb_rdata_exu
    );
endinterface

// File: rtl/ysyx_23060236_btb_2way.sv
// Two-way set-associative branch target buffer with 2-bit saturating direction counters.
// It has two combinational lookup ports (IFU and EXU), one registered update port and a whole-table flush.
module ysyx_23060236_btb_2way #(
    parameter int ADDR_LEN   = 32,
    parameter int DATA_LEN   = 32,
    parameter int OFFSET_LEN = 2,
    parameter int INDEX_LEN  = 4
) (
    input logic                      clock,
    input logic                      reset,
    ysyx_23060236_btb_2way_if.slave  bus
);
    localparam int SETS    = 1 << INDEX_LEN;
    localparam int TAG_LEN = ADDR_LEN - OFFSET_LEN - INDEX_LEN;
    localparam int TAG_LSB = OFFSET_LEN + INDEX_LEN;

    typedef logic [INDEX_LEN-1:0] idx_t;
    typedef logic [TAG_LEN-1:0]   tag_t;

    typedef struct packed {
        logic                taken;
        logic [DATA_LEN-1:0] next_pc;
    } pred_t;

    logic [1:0]          valid_q  [SETS];
    logic [1:0]          ctr_q    [SETS][2];
    tag_t                tag_q    [SETS][2];
    logic [DATA_LEN-1:0] target_q [SETS][2];
    logic [SETS-1:0]     lru_q;

    // ------------------------------------------------------------------
    // Lookup: a pure read of the table, shared by both ports.
    // ------------------------------------------------------------------
    function automatic pred_t predict(input idx_t idx, input tag_t tg,
                                      input logic [ADDR_LEN-1:0] pc);
        pred_t p;
        p.taken   = 1'b0;
        p.next_pc = DATA_LEN'(pc + ADDR_LEN'(4));
        for (int w = 0; w < 2; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tg) && ctr_q[idx][w][1]) begin
                p.taken   = 1'b1;
                p.next_pc = target_q[idx][w];
            end
        end
        return p;
    endfunction

    idx_t  ifu_idx, exu_idx;
    tag_t  ifu_tag, exu_tag;
    pred_t ifu_pred, exu_pred;

    assign ifu_idx = bus.btb_araddr[TAG_LSB-1:OFFSET_LEN];
    assign ifu_tag = bus.btb_araddr[ADDR_LEN-1:TAG_LSB];
    assign exu_idx = bus.btb_araddr_exu[TAG_LSB-1:OFFSET_LEN];
    assign exu_tag = bus.btb_araddr_exu[ADDR_LEN-1:TAG_LSB];

    always_comb begin
        ifu_pred = predict(ifu_idx, ifu_tag, bus.btb_araddr);
        exu_pred = predict(exu_idx, exu_tag, bus.btb_araddr_exu);
    end

    assign bus.btb_rdata      = ifu_pred.next_pc;
    assign bus.btb_pred_taken = ifu_pred.taken;
    assign bus.btb_rdata_exu  = exu_pred.next_pc;

    // ------------------------------------------------------------------
    // Update: decode hit/victim for the addressed set.
    // ------------------------------------------------------------------
    idx_t       upd_idx;
    tag_t       upd_tag;
    logic       upd_en;
    logic [1:0] hit_vec;
    logic       hit_any;
    logic [1:0] victim_oh;
    logic       unused_awaddr_offset;

    assign upd_idx = bus.btb_awaddr[TAG_LSB-1:OFFSET_LEN];
    assign upd_tag = bus.btb_awaddr[ADDR_LEN-1:TAG_LSB];
    assign upd_en  = bus.btb_wvalid && !bus.btb_flush;
    assign unused_awaddr_offset = ^bus.btb_awaddr[OFFSET_LEN-1:0];

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            hit_vec[w] = valid_q[upd_idx][w] && (tag_q[upd_idx][w] == upd_tag);
        end
    end

    assign hit_any = |hit_vec;

    // Invalid ways are filled first (way 0 before way 1); otherwise the LRU way is replaced.
    always_comb begin
        if (!valid_q[upd_idx][0])      victim_oh = 2'b01;
        else if (!valid_q[upd_idx][1]) victim_oh = 2'b10;
        else if (lru_q[upd_idx])       victim_oh = 2'b10;
        else                           victim_oh = 2'b01;
    end

    logic [1:0] ctr_we;
    logic [1:0] ctr_d [2];
    logic [1:0] tgt_we;
    logic [1:0] alloc;
    logic       lru_we;
    logic       lru_d;

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        ctr_we = 2'b00;
        tgt_we = 2'b00;
        alloc  = 2'b00;
        lru_we = 1'b0;
        lru_d  = lru_q[upd_idx];
        for (int w = 0; w < 2; w++) begin
            ctr_d[w] = ctr_q[upd_idx][w];
        end

        if (upd_en) begin
            if (hit_any) begin
                for (int w = 0; w < 2; w++) begin
                    if (hit_vec[w]) begin
                        ctr_we[w] = 1'b1;
                        tgt_we[w] = bus.btb_wtaken;
                        if (bus.btb_wtaken)
                            ctr_d[w] = (ctr_q[upd_idx][w] == 2'd3) ? 2'd3 : ctr_q[upd_idx][w] + 2'd1;
                        else
                            ctr_d[w] = (ctr_q[upd_idx][w] == 2'd0) ? 2'd0 : ctr_q[upd_idx][w] - 2'd1;
                    end
                end
                lru_we = 1'b1;
                lru_d  = hit_vec[0];
            end else if (bus.btb_wtaken) begin
                for (int w = 0; w < 2; w++) begin
                    if (victim_oh[w]) begin
                        alloc[w]  = 1'b1;
                        ctr_we[w] = 1'b1;
                        tgt_we[w] = 1'b1;
                        ctr_d[w]  = 2'd2;
                    end
                end
                lru_we = 1'b1;
                lru_d  = victim_oh[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // State: control bits are reset, and tag/target storage is not.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lru_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= 2'b00;
                for (int w = 0; w < 2; w++) begin
                    ctr_q[s][w] <= 2'd0;
                end
            end
        end else if (bus.btb_flush) begin
            lru_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= 2'b00;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (ctr_we[w]) ctr_q[upd_idx][w]   <= ctr_d[w];
                if (alloc[w])  valid_q[upd_idx][w] <= 1'b1;
            end
            if (lru_we) lru_q[upd_idx] <= lru_d;
        end
    end

    // NOTE: tag and target are array storage with no reset; valid gates them, so their power-up contents never reach an output.
    always_ff @(posedge clock) begin
        for (int w = 0; w < 2; w++) begin
            if (alloc[w])  tag_q[upd_idx][w]    <= upd_tag;
            if (tgt_we[w]) target_q[upd_idx][w] <= bus.btb_wdata;
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_btb_2way.sv
// Directed bench for the 2-way BTB. Expected lookups are queued when driven and popped when sampled.
module tb_ysyx_23060236_btb_2way;
    logic clock;
    logic reset;

    ysyx_23060236_btb_2way_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

    ysyx_23060236_btb_2way #(
        .ADDR_LEN(32), .DATA_LEN(32), .OFFSET_LEN(2), .INDEX_LEN(4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        tk;
        logic [31:0] rd_exu;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "/rdata"},     bus.btb_rdata,                 e.rd);
        check({e.tag, "/taken"},     {31'd0, bus.btb_pred_taken},   {31'd0, e.tk});
        check({e.tag, "/rdata_exu"}, bus.btb_rdata_exu,             e.rd_exu);
    endtask

    task automatic lookup(input string tag, input logic [31:0] a, input logic [31:0] ae,
                          input logic [31:0] erd, input logic etk, input logic [31:0] erde);
        exp_t e;
        bus.btb_araddr     = a;
        bus.btb_araddr_exu = ae;
        e.tag = tag; e.rd = erd; e.tk = etk; e.rd_exu = erde;
        sb.push_back(e);
        #1;
        compare();
    endtask

    // Same address on both ports; the expected value is the target when taken, otherwise PC+4.
    task automatic probe(input string tag, input logic [31:0] a, input logic tk, input logic [31:0] tgt);
        logic [31:0] exp_pc;
        exp_pc = tk ? tgt : a + 32'd4;
        lookup(tag, a, a, exp_pc, tk, exp_pc);
    endtask

    task automatic update(input logic [31:0] a, input logic [31:0] tgt, input logic tk, input logic fl);
        @(negedge clock);
        bus.btb_wvalid = 1'b1;
        bus.btb_awaddr = a;
        bus.btb_wdata  = tgt;
        bus.btb_wtaken = tk;
        bus.btb_flush  = fl;
        @(posedge clock);
        #1;
        bus.btb_wvalid = 1'b0;
        bus.btb_flush  = 1'b0;
    endtask

    initial begin
        reset              = 1'b0;
        bus.btb_araddr     = 32'h0;
        bus.btb_araddr_exu = 32'h0;
        bus.btb_wvalid     = 1'b0;
        bus.btb_awaddr     = 32'h0;
        bus.btb_wdata      = 32'h0;
        bus.btb_wtaken     = 1'b0;
        bus.btb_flush      = 1'b0;

        // Reset held, then released
        #12;
        lookup("rst_hold", 32'h8000_0000, 32'h8000_0010, 32'h8000_0004, 1'b0, 32'h8000_0014);
        @(negedge clock);
        reset = 1'b1;
        probe("rst_rel", 32'h8000_0000, 1'b0, 32'h0);

        // Allocate: the same-cycle lookup sees pre-update contents
        @(negedge clock);
        bus.btb_wvalid = 1'b1;
        bus.btb_awaddr = 32'h8000_0010;
        bus.btb_wdata  = 32'h8000_0100;
        bus.btb_wtaken = 1'b1;
        lookup("alloc_same", 32'h8000_0010, 32'h8000_0010, 32'h8000_0014, 1'b0, 32'h8000_0014);
        @(posedge clock);
        #1;
        bus.btb_wvalid = 1'b0;
        probe("alloc_hit", 32'h8000_0010, 1'b1, 32'h8000_0100);

        // Counter hysteresis
        update(32'h8000_0010, 32'h0, 1'b0, 1'b0);
        probe("ctr1", 32'h8000_0010, 1'b0, 32'h0);
        update(32'h8000_0010, 32'h8000_0200, 1'b1, 1'b0);
        probe("ctr2", 32'h8000_0010, 1'b1, 32'h8000_0200);
        repeat (4) update(32'h8000_0010, 32'h8000_0200, 1'b1, 1'b0);
        update(32'h8000_0010, 32'h0, 1'b0, 1'b0);
        probe("sat3_nt1", 32'h8000_0010, 1'b1, 32'h8000_0200);
        update(32'h8000_0010, 32'h0, 1'b0, 1'b0);
        probe("sat3_nt2", 32'h8000_0010, 1'b0, 32'h0);
        update(32'h8000_0010, 32'h0, 1'b0, 1'b0);
        update(32'h8000_0010, 32'h0, 1'b0, 1'b0);
        update(32'h8000_0010, 32'h8000_0300, 1'b1, 1'b0);
        probe("sat0_t1", 32'h8000_0010, 1'b0, 32'h0);
        update(32'h8000_0010, 32'h8000_0300, 1'b1, 1'b0);
        probe("sat0_t2", 32'h8000_0010, 1'b1, 32'h8000_0300);

        // LRU replacement in set 0
        update(32'h8000_0000, 32'h8000_1000, 1'b1, 1'b0);
        update(32'h8000_0040, 32'h8000_1040, 1'b1, 1'b0);
        update(32'h8000_0000, 32'h8000_1000, 1'b1, 1'b0);
        update(32'h8000_0080, 32'h8000_1080, 1'b1, 1'b0);
        lookup("lru_pair", 32'h8000_0000, 32'h8000_0080, 32'h8000_1000, 1'b1, 32'h8000_1080);
        probe("lru_evicted", 32'h8000_0040, 1'b0, 32'h0);
        update(32'h8000_00C0, 32'h8000_10C0, 1'b1, 1'b0);
        probe("lru0_evict", 32'h8000_0000, 1'b0, 32'h0);
        lookup("lru0_keep", 32'h8000_00C0, 32'h8000_0080, 32'h8000_10C0, 1'b1, 32'h8000_1080);

        // Not-taken miss leaves the table, including lru, untouched
        update(32'h8000_0300, 32'h8000_9999, 1'b0, 1'b0);
        probe("nt_miss", 32'h8000_0300, 1'b0, 32'h0);
        lookup("nt_others", 32'h8000_0080, 32'h8000_0010, 32'h8000_1080, 1'b1, 32'h8000_0300);
        update(32'h8000_0100, 32'h8000_1100, 1'b1, 1'b0);
        probe("nt_lru_evict", 32'h8000_0080, 1'b0, 32'h0);
        lookup("nt_lru_keep", 32'h8000_00C0, 32'h8000_0100, 32'h8000_10C0, 1'b1, 32'h8000_1100);

        // Flush wins over a simultaneous allocate
        update(32'h8000_0500, 32'h8000_1500, 1'b1, 1'b1);
        probe("flush_a", 32'h8000_0010, 1'b0, 32'h0);
        probe("flush_b", 32'h8000_00C0, 1'b0, 32'h0);
        probe("flush_c", 32'h8000_0100, 1'b0, 32'h0);
        probe("flush_new", 32'h8000_0500, 1'b0, 32'h0);

        // Mid-cycle asynchronous reset
        update(32'h8000_0010, 32'h8000_0100, 1'b1, 1'b0);
        probe("reinstall", 32'h8000_0010, 1'b1, 32'h8000_0100);
        @(negedge clock);
        #2;
        reset = 1'b0;
        lookup("async_rst", 32'h8000_0010, 32'h8000_0010, 32'h8000_0014, 1'b0, 32'h8000_0014);

        // Update during reset is dropped
        update(32'h8000_0020, 32'h8000_2020, 1'b1, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        probe("rst_drop", 32'h8000_0020, 1'b0, 32'h0);
        probe("rst_cleared", 32'h8000_0010, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
